stream_demux_collect: RTL and testbench

//   1-to-LANES deserializing demux with valid/ready handshake. Accepts a serial stream of

---
 rtl/stream_demux_collect.sv | 117 +++++++++++
 tb/tb_stream_demux_collect.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_collect.sv
// stream_demux_collect: 1-to-LANES deserializing demux with valid/ready handshakes.
// Serial words are steered round-robin into LANES holding registers; a complete (or
// flushed partial) group is presented in parallel with a count of valid lanes.
module stream_demux_collect #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned CNT_W     = $clog2(LANES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WORD_SIZE-1:0]       in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [LANES*WORD_SIZE-1:0] out_data,
    output logic [CNT_W-1:0]           out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int unsigned IDX_W = $clog2(LANES);

    typedef enum logic [0:0] {StFill, StFull} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WORD_SIZE-1:0]   lane_q [LANES];
    logic [WORD_SIZE-1:0]   lane_d [LANES];
    logic                   in_xfer;
    logic                   out_xfer;

    // Handshake outputs; in FULL the input may only advance when the group leaves.
    always_comb begin
        out_valid = (state_q == StFull);
        in_ready  = !reset && ((state_q == StFill) || out_ready);
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
        out_count = count_q;
    end

    // Flatten lane registers onto the parallel output bus.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < LANES; k++) begin
            out_data[k*WORD_SIZE +: WORD_SIZE] = lane_q[k];
        end
    end

    // Next-state: lane steering, group closing and group hand-off.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        lane_d  = lane_q;
        unique case (state_q)
            StFill: begin
                if (in_xfer) begin
                    lane_d[idx_q] = in_data;
                    // First word of a group clears the rest so flushed groups pad with 0.
                    if (idx_q == '0) begin
                        for (int k = 1; k < LANES; k++) begin
                            lane_d[k] = '0;
                        end
                    end
                    if ((idx_q == IDX_W'(LANES - 1)) || flush) begin
                        state_d = StFull;
                        count_d = CNT_W'(idx_q) + CNT_W'(1);
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (flush && (idx_q != '0)) begin
                    state_d = StFull;
                    count_d = CNT_W'(idx_q);
                    idx_d   = '0;
                end
            end
            StFull: begin
                if (out_xfer) begin
                    state_d = StFill;
                    count_d = '0;
                    idx_d   = '0;
                    // Word arriving on the hand-off cycle opens the next group at lane 0.
                    if (in_xfer) begin
                        lane_d[0] = in_data;
                        for (int k = 1; k < LANES; k++) begin
                            lane_d[k] = '0;
                        end
                        idx_d = IDX_W'(1);
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State registers with synchronous reset; partial data is discarded on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFill;
            idx_q   <= '0;
            count_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            for (int k = 0; k < LANES; k++) begin
                lane_q[k] <= lane_d[k];
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_collect.sv
// Directed bench for stream_demux_collect with WORD_SIZE=16, LANES=4.
module tb_stream_demux_collect;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned LANES     = 4;
    localparam int unsigned CNT_W     = 3;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [WORD_SIZE-1:0]       in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       flush;
    logic [LANES*WORD_SIZE-1:0] out_data;
    logic [CNT_W-1:0]           out_count;
    logic                       out_valid;
    logic                       out_ready;

    int tests_run = 0;
    int tests_failed = 0;

    stream_demux_collect #(
        .WORD_SIZE (WORD_SIZE),
        .LANES     (LANES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present one word for a single cycle; called and returns 1ns after a rising edge.
    task automatic send(input logic [15:0] w, input logic f);
        in_valid = 1'b1;
        in_data  = w;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        int         sent;
        int         groups;
        logic [63:0] exp_grp;
        logic       iv;
        logic       ordy;

        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_count", 64'(out_count), 64'd0);
        check("reset_out_data", out_data, 64'd0);

        // Test 1: full group back-to-back, one-cycle output pulse.
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", out_data, 64'h0004_0003_0002_0001);
        check("t1_count", 64'(out_count), 64'd4);
        @(posedge clk);
        #1;
        check("t1_pulse", 64'(out_valid), 64'd0);

        // Test 2: backpressure while holding a full group.
        out_ready = 1'b0;
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd5;
        #1;
        check("t2_in_ready_blocked", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("t2_held_valid", 64'(out_valid), 64'd1);
        check("t2_held_data", out_data, 64'h0004_0003_0002_0001);
        out_ready = 1'b1;
        #1;
        check("t2_in_ready_passthru", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t2_after_handoff_valid", 64'(out_valid), 64'd0);
        check("t2_lane0_new", out_data, 64'h0000_0000_0000_0005);
        send(16'd6, 1'b0);
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        check("t2_group_data", out_data, 64'h0008_0007_0006_0005);
        check("t2_group_count", 64'(out_count), 64'd4);

        // Test 3: flush alone closes a partial group; flush with idx 0 is ignored.
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("t3_flush_valid", 64'(out_valid), 64'd1);
        check("t3_flush_count", 64'(out_count), 64'd2);
        check("t3_flush_data", out_data, 64'h0000_0000_0008_0007);
        @(posedge clk);
        #1;
        check("t3_consumed", 64'(out_valid), 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("t3_empty_flush", 64'(out_valid), 64'd0);

        // Test 4: flush together with the closing word.
        send(16'd9, 1'b0);
        send(16'd10, 1'b1);
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_count", 64'(out_count), 64'd2);
        check("t4_data", out_data, 64'h0000_0000_000a_0009);
        @(posedge clk);
        #1;
        // Single-word group via flush.
        send(16'h0032, 1'b1);
        check("t4_single_count", 64'(out_count), 64'd1);
        check("t4_single_data", out_data, 64'h0000_0000_0000_0032);
        @(posedge clk);
        #1;
        check("t4_single_consumed", 64'(out_valid), 64'd0);

        // Test 5: 40 words with random gaps on both sides.
        sent   = 0;
        groups = 0;
        for (int cyc = 0; cyc < 2000 && groups < 10; cyc++) begin
            iv   = (sent < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = 1'($urandom_range(0, 1));
            in_valid  = iv;
            in_data   = 16'(100 + sent);
            out_ready = ordy;
            #1;
            if (out_valid && !out_ready) begin
                check("t5_in_ready_full", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                exp_grp = {16'(100 + 4*groups + 3), 16'(100 + 4*groups + 2),
                           16'(100 + 4*groups + 1), 16'(100 + 4*groups)};
                check("t5_group_data", out_data, exp_grp);
                check("t5_group_count", 64'(out_count), 64'd4);
                groups++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t5_groups_seen", 64'(groups), 64'd10);

        // Test 6: reset mid-group discards the partial group.
        @(posedge clk);
        #1;
        send(16'd200, 1'b0);
        send(16'd201, 1'b0);
        send(16'd202, 1'b0);
        reset = 1'b1;
        #1;
        check("t6_in_ready_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6_valid_after_reset", 64'(out_valid), 64'd0);
        check("t6_data_after_reset", out_data, 64'd0);
        send(16'd210, 1'b0);
        send(16'd211, 1'b0);
        send(16'd212, 1'b0);
        check("t6_not_yet_valid", 64'(out_valid), 64'd0);
        send(16'd213, 1'b0);
        check("t6_group_valid", 64'(out_valid), 64'd1);
        check("t6_group_data", out_data, 64'h00d5_00d4_00d3_00d2);
        check("t6_group_count", 64'(out_count), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
